k_select: RTL
=============

// Module: k_select
// PURPOSE
//  Streaming top-K selector, directly upstream of the KNN type-inference stage.
//  - Accepts one (distance, type) pair per cycle for the N training points of a query.
//  - Keeps the K smallest distances in an ordered register list (insertion sort).
//  - After N accepted pairs, presents the K nearest types packed and pulses valid_sort.
// PARAMETERS
//  N       10  training points per query (frame length); K <= N required
//  W       32  distance width, unsigned
//  K       5   neighbours kept
//  TYPE_W  4   type/class label width
// PORTS
//  clk                        in   1         clock, all logic on posedge
//  rst                        in   1         synchronous reset, ACTIVE-LOW (0 = reset)
//  dist_valid                 in   1         dist_in/type_in valid
//  dist_in                    in   W         distance of current training point
//  type_in                    in   TYPE_W    type of current training point
//  dist_ready                 out  1         block can accept; transfer = dist_valid & dist_ready
//  valid_sort                 out  1         one-cycle pulse: K-nearest results valid
//  k_nearest_neighbours_type  out  K*TYPE_W  slot i at [(i+1)*TYPE_W-1 -: TYPE_W], slot 0 nearest
//  k_nearest_neighbours_dist  out  K*W       slot i at [(i+1)*W-1 -: W], same order
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state COLLECT, count=0, all slots invalid, both output
//    buses 0, valid_sort=0, dist_ready=1. Reset mid-frame discards the partial frame.
//  - FSM: COLLECT -> DONE on the N-th transfer. DONE -> COLLECT after exactly 1 cycle.
//  - COLLECT: dist_ready=1. On each transfer, the pair is inserted in one cycle:
//    - Slot i is "above" the new pair if slot i is valid and slot dist <= dist_in.
//    - The new pair goes to the first slot not above it.
//    - Lower slots shift down one; slot K-1 drops off.
//    - If every slot is above it, the pair is discarded.
//    - Ties: the earlier-arrived pair keeps the lower index (strict < to overtake).
//  - Per-slot valid bits handle empty slots. A distance of all-ones is a legal value
//    and is never treated as empty.
//  - count (width $clog2(N+1)) counts transfers only; idle cycles (dist_valid=0) are
//    ignored.
//  - N-th transfer at edge t:
//    - the list update completes at edge t;
//    - state=DONE and valid_sort=1 from edge t to edge t+1, exactly one cycle;
//    - in DONE: dist_ready=0, no transfer is possible, count clears to 0.
//  - Output buses are registered copies of the list and always reflect it.
//    - They hold the completed frame's result from the valid_sort cycle until the first
//      transfer of the next frame.
//    - That first transfer clears all slot valid bits and writes the new pair to slot 0,
//      so frames never mix.
//  - Fields of invalid slots drive 0.
//  - dist_in/type_in are sampled only on a transfer. Latency from last transfer to
//    valid_sort is 1 edge.
//  - No throughput loss inside a frame (1 pair/cycle); 1 bubble cycle between frames.
// TESTING
//  1. Distances 9,8,...,0 with types 9..0 (one per cycle) -> after 10th transfer
//     valid_sort=1 for 1 cycle; types slot0..4 = 0,1,2,3,4; dists = 0,1,2,3,4.
//  2. All distances 5, types 0..9 -> types slot0..4 = 0,1,2,3,4 (arrival order on ties).
//  3. Ascending 0..9 with dist_valid low on alternate cycles -> valid_sort only after
//     the 10th transfer; types = 0..4; no pulse earlier.
//  4. rst=0 after 6 transfers, then a full frame dists 20,3,7,3,1,50,2,9,4,8 types 0..9
//     -> no pulse for the partial frame; result types = 4,6,1,3,8 (dists 1,2,3,3,4).
//  5. Back-to-back frames with dist_valid held high -> dist_ready=0 in the valid_sort
//     cycle; frame-1 outputs hold until frame-2's first transfer; frame-2 result is
//     independent of frame 1.
//  6. Dists 32'hFFFFFFFF x6 then 3,1,2,0 -> types of dists 0,1,2,3 in slots 0..3;
//     slot 4 = first all-ones pair (type 0), dist = 32'hFFFFFFFF.

Source files
------------

// File: rtl/k_select_if.sv
// Stream interface of the top-K selector: one distance/type pair in per transfer,
// and the packed K-nearest result plus its one-cycle valid pulse out.
interface k_select_if #(
  parameter int W      = 32,
  parameter int TYPE_W = 4,
  parameter int K      = 5
) ();
  logic                dist_valid;
  logic [W-1:0]        dist_in;
  logic [TYPE_W-1:0]   type_in;
  logic                dist_ready;
  logic                valid_sort;
  logic [K*TYPE_W-1:0] k_nearest_neighbours_type;
  logic [K*W-1:0]      k_nearest_neighbours_dist;

  modport master (
    output dist_valid,
    output dist_in,
    output type_in,
    input  dist_ready,
    input  valid_sort,
    input  k_nearest_neighbours_type,
    input  k_nearest_neighbours_dist
  );

  modport slave (
    input  dist_valid,
    input  dist_in,
    input  type_in,
    output dist_ready,
    output valid_sort,
    output k_nearest_neighbours_type,
    output k_nearest_neighbours_dist
  );
endinterface

// File: rtl/k_select.sv
// Streaming top-K selector: insertion-sorts N (distance, type) pairs per frame into a
// K-entry ordered list and pulses valid_sort once the frame's last pair is in.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | accepting pairs; dist_ready=1, list updated on each transfer
// DONE    | frame complete; valid_sort=1, dist_ready=0, count cleared
module k_select #(
  parameter int N      = 10,
  parameter int W      = 32,
  parameter int K      = 5,
  parameter int TYPE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  k_select_if.slave  sif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [W-1:0]      dist_q [K];
  logic [W-1:0]      dist_d [K];
  logic [TYPE_W-1:0] type_q [K];
  logic [TYPE_W-1:0] type_d [K];
  logic [K-1:0]      vld_q, vld_d;

  logic              xfer;
  logic              first_xfer;
  logic [K-1:0]      live;
  logic [K-1:0]      above;

  // The first transfer of a frame sees an empty list, so the previous result
  // stays visible on the outputs right up to that transfer and never mixes in.
  always_comb begin
    xfer       = sif.dist_valid && (state_q == COLLECT);
    first_xfer = (count_q == '0);
    live       = first_xfer ? '0 : vld_q;
    above      = '0;
    for (int i = 0; i < K; i++) begin
      above[i] = live[i] && (dist_q[i] <= sif.dist_in);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    vld_d   = vld_q;
    for (int i = 0; i < K; i++) begin
      dist_d[i] = dist_q[i];
      type_d[i] = type_q[i];
    end

    case (state_q)
      COLLECT: begin
        if (xfer) begin
          count_d = count_q + CW'(1);
          vld_d   = live;
          // above[] is a prefix of the list; the new pair lands on its first
          // zero and everything below moves down one, dropping slot K-1.
          if (!above[0]) begin
            dist_d[0] = sif.dist_in;
            type_d[0] = sif.type_in;
            vld_d[0]  = 1'b1;
          end
          for (int i = 1; i < K; i++) begin
            if (!above[i]) begin
              if (above[i-1]) begin
                dist_d[i] = sif.dist_in;
                type_d[i] = sif.type_in;
                vld_d[i]  = 1'b1;
              end else begin
                dist_d[i] = dist_q[i-1];
                type_d[i] = type_q[i-1];
                vld_d[i]  = live[i-1];
              end
            end
          end
          if (count_q == CW'(N - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = COLLECT;
        count_d = '0;
      end
      default: begin
        state_d = COLLECT;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= COLLECT;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= '0;
        type_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= dist_d[i];
        type_q[i] <= type_d[i];
      end
    end
  end

  assign sif.dist_ready = (state_q == COLLECT);
  assign sif.valid_sort = (state_q == DONE);

  always_comb begin
    sif.k_nearest_neighbours_type = '0;
    sif.k_nearest_neighbours_dist = '0;
    for (int i = 0; i < K; i++) begin
      sif.k_nearest_neighbours_type[i*TYPE_W +: TYPE_W] = vld_q[i] ? type_q[i] : '0;
      sif.k_nearest_neighbours_dist[i*W +: W]           = vld_q[i] ? dist_q[i] : '0;
    end
  end

endmodule
